// File: rtl/dly_pipe.sv
// Selectable-tap delay line: DEPTH clock-enabled stages, each holding data plus a valid bit.
// The output mux picks one stage combinationally; occupancy and busy come from the valid bits.
module dly_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int SEL_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ce,
  input  logic             i_flush,
  input  logic [SEL_W-1:0] i_dly_sel,
  input  logic             i_din_valid,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_dout_valid,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_busy,
  output logic [SEL_W-1:0] o_occ,
  output logic             o_sel_err
);

  localparam logic [SEL_W-1:0] LP_DEPTH = SEL_W'(DEPTH);

  logic [WIDTH-1:0] r_data [1:DEPTH];
  logic             r_vld  [1:DEPTH];
  logic             r_sel_err;

  logic             w_sel_bad;
  logic [SEL_W-1:0] w_tap;
  logic             w_vld;
  logic [WIDTH-1:0] w_data;
  logic [SEL_W-1:0] w_occ;

  // Out-of-range selects fall back to the deepest tap.
  assign w_sel_bad = (i_dly_sel == '0) || (i_dly_sel > LP_DEPTH);
  assign w_tap     = w_sel_bad ? LP_DEPTH : i_dly_sel;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      for (int k = 1; k <= DEPTH; k++) begin
        r_data[k] <= '0;
        r_vld[k]  <= 1'b0;
      end
    end else if (i_ce) begin
      r_data[1] <= i_din;
      r_vld[1]  <= i_din_valid;
      for (int k = 2; k <= DEPTH; k++) begin
        r_data[k] <= r_data[k-1];
        r_vld[k]  <= r_vld[k-1];
      end
    end
  end

  // The select check runs every edge, stalled or flushed alike.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sel_err <= 1'b0;
    end else begin
      r_sel_err <= w_sel_bad;
    end
  end

  always_comb begin
    w_vld  = 1'b0;
    w_data = '0;
    w_occ  = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (w_tap == SEL_W'(k)) begin
        w_vld  = r_vld[k];
        w_data = r_data[k];
      end
      w_occ = w_occ + SEL_W'(r_vld[k]);
    end
  end

  assign o_dout_valid = w_vld;
  assign o_dout       = w_vld ? w_data : '0;
  assign o_busy       = (w_occ != '0);
  assign o_occ        = w_occ;
  assign o_sel_err    = r_sel_err;

endmodule

// File: tb/tb_dly_pipe.sv
// Self-checking bench for dly_pipe: directed scenarios plus a random run, all compared
// against a history-queue model of accepted samples.
module tb_dly_pipe;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_ce = 1'b0;
  logic       i_flush = 1'b0;
  logic [2:0] i_dly_sel = 3'd1;
  logic       i_din_valid = 1'b0;
  logic [7:0] i_din = 8'h00;
  logic       o_dout_valid;
  logic [7:0] o_dout;
  logic       o_busy;
  logic [2:0] o_occ;
  logic       o_sel_err;

  int n_total = 0;
  int n_pass  = 0;

  dly_pipe #(.WIDTH(8), .DEPTH(4), .SEL_W(3)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ce(i_ce), .i_flush(i_flush),
    .i_dly_sel(i_dly_sel), .i_din_valid(i_din_valid), .i_din(i_din),
    .o_dout_valid(o_dout_valid), .o_dout(o_dout), .o_busy(o_busy),
    .o_occ(o_occ), .o_sel_err(o_sel_err)
  );

  always #5 i_clk = ~i_clk;

  // Model: the last DEPTH samples taken on enabled edges, newest at the back.
  localparam int DEPTH = 4;
  logic [8:0] hist[$];
  logic       m_sel_err = 1'b0;

  wire [13:0] act = {o_dout_valid, o_dout, o_busy, o_occ, o_sel_err};

  function automatic logic [13:0] model_out(input logic [2:0] sel);
    int t;
    logic v;
    logic [7:0] d;
    logic [2:0] oc;
    t = (sel >= 3'd1 && int'(sel) <= DEPTH) ? int'(sel) : DEPTH;
    v = 1'b0;
    d = 8'h00;
    oc = 3'd0;
    if (hist.size() >= t) begin
      v = hist[hist.size() - t][8];
      d = v ? hist[hist.size() - t][7:0] : 8'h00;
    end
    foreach (hist[i]) oc = oc + {2'b00, hist[i][8]};
    return {v, d, (oc != 3'd0), oc, m_sel_err};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    if (i_rst) begin
      hist.delete();
      m_sel_err = 1'b0;
    end else begin
      m_sel_err = (i_dly_sel == 3'd0) || (int'(i_dly_sel) > DEPTH);
      if (i_flush) hist.delete();
      else if (i_ce) begin
        hist.push_back({i_din_valid, i_din});
        if (hist.size() > DEPTH) void'(hist.pop_front());
      end
    end
    #1;
  endtask

  task automatic clear();
    i_rst = 1'b0; i_flush = 1'b1; i_ce = 1'b1; i_din_valid = 1'b0;
    tick();
    i_flush = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_ce = 1'b1; i_din_valid = 1'b1; i_din = 8'h5A; i_dly_sel = 3'd0;
    tick();
    tick();
    n_total++;
    if (act !== 14'h0) $display("FAIL reset_outputs: got %h need %h", act, 14'h0);
    else n_pass++;
    i_rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [13:0] e;
    logic [2:0]  peak;
    clear();
    i_dly_sel = 3'd3;
    peak = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      i_din_valid = (k <= 3);
      i_din = (k <= 3) ? 8'(8'h11 * k) : 8'($urandom);
      tick();
      e = model_out(i_dly_sel);
      n_total++;
      if (act !== e) $display("FAIL basic_model edge %0d: got %h need %h", k, act, e);
      else n_pass++;
      if (o_occ > peak) peak = o_occ;
      if (k >= 3 && k <= 5) begin
        n_total++;
        if (!o_dout_valid || o_dout !== 8'(8'h11 * (k - 2)))
          $display("FAIL basic_dout edge %0d: got %b/%h need 1/%h", k, o_dout_valid, o_dout, 8'(8'h11 * (k - 2)));
        else n_pass++;
      end
      if (k == 6 || k == 7) begin
        n_total++;
        if (o_busy !== (k == 6)) $display("FAIL basic_busy edge %0d: got %b need %b", k, o_busy, (k == 6));
        else n_pass++;
      end
    end
    n_total++;
    if (peak !== 3'd3) $display("FAIL basic_occ_peak: got %0d need 3", peak);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [13:0] e;
    clear();
    i_dly_sel = 3'd4;
    for (int k = 1; k <= 7; k++) begin
      i_ce = !(k == 2 || k == 3);
      i_din_valid = (k <= 3);
      i_din = (k == 1) ? 8'hA5 : 8'($urandom);
      tick();
      e = model_out(i_dly_sel);
      n_total++;
      if (act !== e) $display("FAIL stall_model edge %0d: got %h need %h", k, act, e);
      else n_pass++;
      if (k == 6) begin
        n_total++;
        if (!o_dout_valid || o_dout !== 8'hA5) $display("FAIL stall_dout: got %b/%h need 1/a5", o_dout_valid, o_dout);
        else n_pass++;
      end
      if (k == 2 || k == 3) begin
        n_total++;
        if (o_occ !== 3'd1 || o_dout_valid !== 1'b0) $display("FAIL stall_hold edge %0d: got occ %0d v %b need 1 0", k, o_occ, o_dout_valid);
        else n_pass++;
      end
    end
    i_ce = 1'b1;
  endtask

  task automatic test_flush();
    logic [13:0] e;
    clear();
    i_dly_sel = 3'd4;
    for (int k = 1; k <= 4; k++) begin
      i_din_valid = 1'b1; i_din = 8'(k);
      tick();
    end
    i_flush = 1'b1; i_din = 8'h05;
    tick();
    n_total++;
    if (act !== 14'h0) $display("FAIL flush_outputs: got %h need %h", act, 14'h0);
    else n_pass++;
    i_flush = 1'b0; i_din_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      i_dly_sel = 3'(1 + (k % 4));
      tick();
      e = model_out(i_dly_sel);
      n_total++;
      if (act !== e || o_dout == 8'h05) $display("FAIL flush_after edge %0d: got %h need %h", k, act, e);
      else n_pass++;
    end
  endtask

  task automatic test_sel_err();
    logic [13:0] e;
    logic [2:0]  sels [3];
    logic        errs [3];
    sels = '{3'd0, 3'd7, 3'd2};
    errs = '{1'b1, 1'b1, 1'b0};
    clear();
    i_dly_sel = 3'd2;
    for (int k = 0; k < 4; k++) begin
      i_din_valid = 1'b1; i_din = 8'($urandom);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      i_dly_sel = sels[k]; i_din = 8'($urandom);
      tick();
      e = model_out(i_dly_sel);
      n_total++;
      if (o_sel_err !== errs[k] || act !== e)
        $display("FAIL sel_err sel=%0d: got %h need %h", sels[k], act, e);
      else n_pass++;
    end
  endtask

  task automatic test_sel_switch();
    logic [13:0] e;
    clear();
    i_dly_sel = 3'd4;
    for (int k = 0; k < 8; k++) begin
      i_din_valid = 1'b1; i_din = 8'(8'h10 + k);
      tick();
      if (k == 4) begin
        i_dly_sel = 3'd1;
        #1;
        n_total++;
        if (o_dout_valid !== 1'b1 || o_dout !== 8'h14) $display("FAIL sel_switch_now: got %b/%h need 1/14", o_dout_valid, o_dout);
        else n_pass++;
      end
      e = model_out(i_dly_sel);
      n_total++;
      if (act !== e) $display("FAIL sel_switch_model k %0d: got %h need %h", k, act, e);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [13:0] e;
    clear();
    i_dly_sel = 3'd2;
    for (int k = 0; k < 3; k++) begin
      i_din_valid = 1'b1; i_din = 8'($urandom);
      tick();
    end
    i_rst = 1'b1;
    tick();
    n_total++;
    if (act !== 14'h0) $display("FAIL reset_mid_outputs: got %h need %h", act, 14'h0);
    else n_pass++;
    i_rst = 1'b0; i_din_valid = 1'b1; i_din = 8'h77;
    tick();
    e = model_out(i_dly_sel);
    n_total++;
    if (act !== e || o_dout_valid !== 1'b0) $display("FAIL reset_mid_first: got %h need %h", act, e);
    else n_pass++;
    i_din_valid = 1'b0;
    tick();
    n_total++;
    if (o_dout_valid !== 1'b1 || o_dout !== 8'h77) $display("FAIL reset_mid_77: got %b/%h need 1/77", o_dout_valid, o_dout);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [13:0] e;
    for (int k = 0; k < 400; k++) begin
      i_rst       = ($urandom_range(0, 59) == 0);
      i_flush     = ($urandom_range(0, 24) == 0);
      i_ce        = ($urandom_range(0, 3) != 0);
      i_din_valid = ($urandom_range(0, 2) != 0);
      i_din       = 8'($urandom);
      if ($urandom_range(0, 5) == 0) i_dly_sel = 3'($urandom_range(0, 7));
      tick();
      i_dly_sel = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : i_dly_sel;
      #1;
      e = model_out(i_dly_sel);
      n_total++;
      if (act !== e) $display("FAIL random k %0d sel %0d: got %h need %h", k, i_dly_sel, act, e);
      else n_pass++;
    end
    i_rst = 1'b0; i_flush = 1'b0; i_ce = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_flush();
    test_sel_err();
    test_sel_switch();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
